// File: rtl/p21_vga_rx.sv
// VGA sync receiver: recovers pixel/line position, measures timing and tracks lock.
// Define P21_VGA_RX_ERR_CNT_EN to build the saturating sync-error counter.
module p21_vga_rx #(
    parameter int H_TOTAL    = 801,
    parameter int V_TOTAL    = 526,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_LOAD     = 658,
    parameter int V_LOAD     = 491,
    parameter int LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] haddr,
    output logic [9:0] vaddr,
    output logic       de,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic [7:0] err_cnt
);

    localparam int GW = $clog2(LOCK_LINES + 1);

    localparam logic [9:0]    HLAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]    VLAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HTOT  = 10'(H_TOTAL);
    localparam logic [9:0]    VTOT  = 10'(V_TOTAL);
    localparam logic [9:0]    HACT  = 10'(H_ACTIVE);
    localparam logic [9:0]    VACT  = 10'(V_ACTIVE);
    localparam logic [9:0]    HLD   = 10'(H_LOAD);
    localparam logic [9:0]    VLD   = 10'(V_LOAD);
    localparam logic [9:0]    CMAX  = 10'd1023;
    localparam logic [GW-1:0] GLOCK = GW'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic          hs_q, vs_q;
    logic [9:0]    haddr_q, haddr_d;
    logic [9:0]    vaddr_q, vaddr_d;
    logic [9:0]    lcnt_q, lcnt_d;
    logic [9:0]    line_len_q, line_len_d;
    logic [9:0]    fcnt_q, fcnt_d;
    logic [9:0]    frame_lines_q, frame_lines_d;
    logic [GW-1:0] good_q, good_d;
    logic          sync_err_q, sync_err_d;

    logic       hfall, vfall, hwrap, lsat, line_ok, frame_ok;
    logic [9:0] meas;

    assign hfall    = hs_q & ~hsync;
    assign vfall    = vs_q & ~vsync;
    assign hwrap    = ~hfall & (haddr_q == HLAST);
    assign meas     = lcnt_q + 10'd1;
    // The cycle on which the line counter first hits its ceiling.
    assign lsat     = ~hfall & (lcnt_q == CMAX - 10'd1);
    assign line_ok  = (meas == HTOT);
    assign frame_ok = (fcnt_q == VTOT);

    always_comb begin
        haddr_d       = haddr_q + 10'd1;
        vaddr_d       = vaddr_q;
        lcnt_d        = lcnt_q;
        line_len_d    = line_len_q;
        fcnt_d        = fcnt_q;
        frame_lines_d = frame_lines_q;
        if (hfall) begin
            haddr_d = HLD;
        end else if (hwrap) begin
            haddr_d = '0;
        end
        if (vfall) begin
            vaddr_d = VLD;
        end else if (hwrap) begin
            vaddr_d = (vaddr_q == VLAST) ? '0 : vaddr_q + 10'd1;
        end
        if (hfall) begin
            lcnt_d     = '0;
            line_len_d = meas;
        end else if (lcnt_q != CMAX) begin
            lcnt_d = lcnt_q + 10'd1;
        end
        if (vfall) begin
            frame_lines_d = fcnt_q;
            fcnt_d        = hfall ? 10'd1 : 10'd0;
        end else if (hfall && fcnt_q != CMAX) begin
            fcnt_d = fcnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        sync_err_d = 1'b0;
        unique case (state_q)
            SEARCH: begin
                good_d = '0;
                if (hfall) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (lsat) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end else if (hfall) begin
                    if (line_ok) begin
                        good_d = good_q + GW'(1);
                        if (good_d == GLOCK) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if ((hfall && !line_ok) || (vfall && !frame_ok) || lsat) begin
                    state_d    = SEARCH;
                    good_d     = '0;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            haddr_q       <= '0;
            vaddr_q       <= '0;
            lcnt_q        <= '0;
            line_len_q    <= '0;
            fcnt_q        <= '0;
            frame_lines_q <= '0;
            good_q        <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hsync;
            vs_q          <= vsync;
            haddr_q       <= haddr_d;
            vaddr_q       <= vaddr_d;
            lcnt_q        <= lcnt_d;
            line_len_q    <= line_len_d;
            fcnt_q        <= fcnt_d;
            frame_lines_q <= frame_lines_d;
            good_q        <= good_d;
            sync_err_q    <= sync_err_d;
        end
    end

`ifdef P21_VGA_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt_q <= '0;
        end else if (sync_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign haddr       = haddr_q;
    assign vaddr       = vaddr_q;
    assign locked      = (state_q == LOCKED);
    assign de          = locked & (haddr_q < HACT) & (vaddr_q < VACT);
    assign sync_err    = sync_err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_p21_vga_rx.sv
// Directed bench for p21_vga_rx: a cycle-level sync generator drives the receiver.
// The frame is shortened to 12 lines to keep the run short; line timing is full size.
module tb_p21_vga_rx;

    localparam int HT = 801;
    localparam int VT = 12;
    localparam int VA = 8;
    localparam int VL = 9;

`ifdef P21_VGA_RX_ERR_CNT_EN
    localparam bit ERRC_EN = 1'b1;
`else
    localparam bit ERRC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       hsync, vsync;
    logic [9:0] haddr, vaddr, line_len, frame_lines;
    logic       de, locked, sync_err;
    logic [7:0] err_cnt;

    int vectors = 0;
    int miscompares = 0;

    int hc, vc;
    int stall = 0;
    bit skip = 1'b0;
    int skip_line = 0;
    bit force_hi = 1'b0;
    bit prev_hs = 1'b1, prev_vs = 1'b1;
    bit hf, vf;
    int pulses = 0;

    p21_vga_rx #(
        .V_TOTAL (VT),
        .V_ACTIVE(VA),
        .V_LOAD  (VL)
    ) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .hsync      (hsync),
        .vsync      (vsync),
        .haddr      (haddr),
        .vaddr      (vaddr),
        .de         (de),
        .locked     (locked),
        .sync_err   (sync_err),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // One generator cycle; syncs are derived from the position after the edge.
    task automatic step();
        int nh, nv;
        nh = (hc == HT - 1) ? 0 : hc + 1;
        nv = (hc == HT - 1) ? ((vc == VT - 1) ? 0 : vc + 1) : vc;
        if (stall > 0 && hc == 100) begin
            nh = hc;
            nv = vc;
            stall--;
        end
        if (skip && hc == HT - 1 && vc == skip_line) begin
            nv = vc + 2;
            skip = 1'b0;
        end
        hsync = force_hi ? 1'b1 : !(nh >= 658 && nh < 754);
        vsync = !(nv == VL || nv == VL + 1);
        @(posedge clk);
        #1;
        hf = prev_hs & ~hsync;
        vf = prev_vs & ~vsync;
        prev_hs = hsync;
        prev_vs = vsync;
        hc = nh;
        vc = nv;
        if (sync_err) pulses++;
    endtask

    task automatic relock_check(input string tag);
        int n = 0;
        bit done = 1'b0;
        for (int i = 0; i < 8 * HT && !done; i++) begin
            step();
            if (hf) begin
                n++;
                if (n == 4) begin
                    vectors++;
                    if (locked !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s_hf4: locked=%b want 0", tag, locked);
                    end
                end
                if (n == 5) begin
                    vectors++;
                    if (locked !== 1'b1) begin
                        miscompares++;
                        $display("FAIL %s_hf5: locked=%b want 1", tag, locked);
                    end
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: hfalls=%0d want 5", tag, n);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        vectors++;
        if ({haddr, vaddr, line_len, frame_lines, err_cnt, de, locked, sync_err} !== '0) begin
            miscompares++;
            $display("FAIL %s: haddr=%0d vaddr=%0d len=%0d lines=%0d err=%0d de=%b lk=%b se=%b want all 0",
                     tag, haddr, vaddr, line_len, frame_lines, err_cnt, de, locked, sync_err);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset");
        sys_rst = 1'b0;
        hc = 0;
        vc = 6;
    endtask

    task automatic test_lock();
        int nhf = 0, nvf = 0, amis = 0;
        pulses = 0;
        for (int i = 0; i < 30 * HT && nvf < 2; i++) begin
            step();
            if (vf) nvf++;
            if (hf) begin
                nhf++;
                if (nhf == 2) begin
                    vectors++;
                    if (line_len !== 10'd801) begin
                        miscompares++;
                        $display("FAIL line_len: got %0d want 801", line_len);
                    end
                end
                if (nhf == 4) begin
                    vectors++;
                    if (locked !== 1'b0) begin
                        miscompares++;
                        $display("FAIL lock_hf4: locked=%b want 0", locked);
                    end
                end
                if (nhf == 5) begin
                    vectors++;
                    if (locked !== 1'b1) begin
                        miscompares++;
                        $display("FAIL lock_hf5: locked=%b want 1", locked);
                    end
                end
            end
            if (nvf >= 1 && (haddr !== 10'(hc) || vaddr !== 10'(vc))) begin
                if (amis == 0)
                    $display("FAIL align: rx=(%0d,%0d) want (%0d,%0d)", haddr, vaddr, hc, vc);
                amis++;
            end
        end
        vectors++;
        if (nvf < 2) begin
            miscompares++;
            $display("FAIL lock_timeout: vfalls=%0d want 2", nvf);
        end else if (frame_lines !== 10'(VT)) begin
            miscompares++;
            $display("FAIL frame_lines: got %0d want %0d", frame_lines, VT);
        end
        vectors++;
        if (amis != 0) begin
            miscompares++;
            $display("FAIL align_total: %0d cycles off, want 0", amis);
        end
        vectors++;
        if (pulses != 0 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_clean: pulses=%0d locked=%b want 0,1", pulses, locked);
        end
    endtask

    task automatic test_de();
        int phase = 0;
        for (int i = 0; i < 3 * VT * HT && phase < 4; i++) begin
            step();
            case (phase)
                0: if (hc == 0 && vc == 0) begin
                    vectors++;
                    if (de !== 1'b1) begin
                        miscompares++;
                        $display("FAIL de_0_0: de=%b want 1", de);
                    end
                    phase = 1;
                end
                1: if (hc == 639 && vc == VA - 1) begin
                    vectors++;
                    if (de !== 1'b1 || haddr !== 10'd639) begin
                        miscompares++;
                        $display("FAIL de_639: de=%b haddr=%0d want 1,639", de, haddr);
                    end
                    phase = 2;
                end
                2: begin
                    vectors++;
                    if (de !== 1'b0 || haddr !== 10'd640) begin
                        miscompares++;
                        $display("FAIL de_640: de=%b haddr=%0d want 0,640", de, haddr);
                    end
                    phase = 3;
                end
                default: if (hc == 0 && vc == VA) begin
                    vectors++;
                    if (de !== 1'b0) begin
                        miscompares++;
                        $display("FAIL de_row%0d: de=%b want 0", VA, de);
                    end
                    phase = 4;
                end
            endcase
        end
        if (phase < 4) begin
            vectors++;
            miscompares++;
            $display("FAIL de_timeout: phase=%0d want 4", phase);
        end
    endtask

    task automatic test_stretch();
        bit seen = 1'b0;
        pulses = 0;
        stall = 4;
        for (int i = 0; i < 2 * HT && !seen; i++) begin
            step();
            seen = hf;
        end
        vectors++;
        if (!seen || line_len !== 10'd805 || sync_err !== 1'b1) begin
            miscompares++;
            $display("FAIL stretch_hf: seen=%b len=%0d se=%b want 1,805,1", seen, line_len, sync_err);
        end
        repeat (20) step();
        vectors++;
        if (pulses != 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL stretch_err: pulses=%0d locked=%b want 1,0", pulses, locked);
        end
        vectors++;
        if (err_cnt !== (ERRC_EN ? 8'd1 : 8'd0)) begin
            miscompares++;
            $display("FAIL stretch_cnt: err_cnt=%0d want %0d", err_cnt, ERRC_EN ? 1 : 0);
        end
        relock_check("stretch_relock");
    endtask

    task automatic test_drop_line();
        bit seen = 1'b0;
        pulses = 0;
        skip = 1'b1;
        skip_line = 3;
        for (int i = 0; i < 2 * VT * HT && !seen; i++) begin
            step();
            seen = vf;
        end
        vectors++;
        if (!seen || sync_err !== 1'b1 || frame_lines !== 10'(VT - 1)) begin
            miscompares++;
            $display("FAIL drop_vf: seen=%b se=%b lines=%0d want 1,1,%0d", seen, sync_err, frame_lines, VT - 1);
        end
        repeat (20) step();
        vectors++;
        if (pulses != 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_err: pulses=%0d locked=%b want 1,0", pulses, locked);
        end
        vectors++;
        if (err_cnt !== (ERRC_EN ? 8'd2 : 8'd0)) begin
            miscompares++;
            $display("FAIL drop_cnt: err_cnt=%0d want %0d", err_cnt, ERRC_EN ? 2 : 0);
        end
        relock_check("drop_relock");
    endtask

    task automatic test_hold_high();
        for (int i = 0; i < 2 * HT && hc != 700; i++) step();
        pulses = 0;
        force_hi = 1'b1;
        repeat (1100) step();
        force_hi = 1'b0;
        vectors++;
        if (pulses != 1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_err: pulses=%0d locked=%b want 1,0", pulses, locked);
        end
        vectors++;
        if (err_cnt !== (ERRC_EN ? 8'd3 : 8'd0)) begin
            miscompares++;
            $display("FAIL hold_cnt: err_cnt=%0d want %0d", err_cnt, ERRC_EN ? 3 : 0);
        end
        relock_check("hold_relock");
    endtask

    task automatic test_reset_mid();
        repeat (50) step();
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: locked=%b want 1", locked);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        check_outs_zero("rst_mid");
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sys_rst = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (sync_err) pulses++;
        end
        vectors++;
        if (pulses != 0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after: pulses=%0d locked=%b want 0,0", pulses, locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_de();
        test_stretch();
        test_drop_line();
        test_hold_high();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
